// File: rtl/matmul_sequencer_pkg.sv
// rtl/matmul_sequencer_pkg.sv - shared state encoding and sizing helpers for the matmul sequencer
package matmul_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Index width for n entries; a single-entry dimension still gets one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

   // The operand-buffer read adds one stage ahead of the datapath latency.
   function automatic int pipe_lat(input int dp_latency);
      return 1 + dp_latency;
   endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// rtl/matmul_sequencer_if.sv - host, operand-buffer, datapath and result-store signals of the sequencer
interface matmul_sequencer_if #(
   parameter int RW  = 2,
   parameter int CW  = 2,
   parameter int RES = 67
);
   logic           start;
   logic           hold;
   logic           busy;
   logic           done;
   logic [RW-1:0]  a_row_addr;
   logic [CW-1:0]  b_col_addr;
   logic           op_read;
   logic [RES-1:0] dot_product;
   logic           res_we;
   logic [RW-1:0]  res_row;
   logic [CW-1:0]  res_col;
   logic [RES-1:0] res_data;

   modport master (
      input  start, hold, dot_product,
      output busy, done, a_row_addr, b_col_addr, op_read,
             res_we, res_row, res_col, res_data
   );

   modport slave (
      output start, hold, dot_product,
      input  busy, done, a_row_addr, b_col_addr, op_read,
             res_we, res_row, res_col, res_data
   );
endinterface

// File: rtl/matmul_sequencer_tag_pipe.sv
// rtl/matmul_sequencer_tag_pipe.sv - fixed-depth shift register carrying {valid,row,col} tags
module mm_tag_pipe #(
   parameter int DEPTH = 4,
   parameter int W     = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         in_valid_i,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   output logic [W-1:0] out_data_o,
   output logic         empty_o
);
   logic [DEPTH-1:0] vld_q;
   logic [W-1:0]     dat_q [DEPTH];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= '0;
         for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
      end else begin
         vld_q[0] <= in_valid_i;
         dat_q[0] <= in_data_i;
         for (int i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
         end
      end
   end

   assign out_valid_o = vld_q[DEPTH-1];
   assign out_data_o  = dat_q[DEPTH-1];
   assign empty_o     = ~|vld_q;
endmodule

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - walks every (row,col) of C = A x B, issues operand reads, writes tagged results
module matmul_sequencer
   import matmul_sequencer_pkg::*;
#(
   parameter int M_ROWS       = 4,
   parameter int N_COLS       = 4,
   parameter int DIM          = 8,
   parameter int A_DATA_WIDTH = 32,
   parameter int B_DATA_WIDTH = 32,
   parameter int DP_LATENCY   = 3
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   matmul_sequencer_if.master bus
);
   localparam int RW       = clog2_min1(M_ROWS);
   localparam int CW       = clog2_min1(N_COLS);
   localparam int RES      = A_DATA_WIDTH + B_DATA_WIDTH + clog2_min1(DIM);
   localparam int PIPE_LAT = pipe_lat(DP_LATENCY);
   localparam logic [RW-1:0] ROW_LAST = RW'(M_ROWS - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);

   state_e         state_q, state_d;
   logic [RW-1:0]  row_q, row_d;
   logic [CW-1:0]  col_q, col_d;
   logic           issue;
   logic           pipe_empty;
   logic           tail_valid;
   logic [RW+CW-1:0] tail_data;

   logic           res_we_q;
   logic [RW-1:0]  res_row_q;
   logic [CW-1:0]  res_col_q;
   logic [RES-1:0] res_data_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      issue   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!bus.hold) begin
               issue = 1'b1;
               // The final pair leaves the counters parked; they clear on the way out of DONE.
               if (row_q == ROW_LAST && col_q == COL_LAST) begin
                  state_d = ST_DRAIN;
               end else if (col_q == COL_LAST) begin
                  col_d = '0;
                  row_d = row_q + RW'(1);
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (pipe_empty) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            row_d   = '0;
            col_d   = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Shifts every cycle: the datapath has no stall, so Hold only gates new issues.
   mm_tag_pipe #(
      .DEPTH (PIPE_LAT),
      .W     (RW + CW)
   ) u_tag_pipe (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .in_valid_i  (issue),
      .in_data_i   ({row_q, col_q}),
      .out_valid_o (tail_valid),
      .out_data_o  (tail_data),
      .empty_o     (pipe_empty)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         res_we_q   <= 1'b0;
         res_row_q  <= '0;
         res_col_q  <= '0;
         res_data_q <= '0;
      end else begin
         res_we_q <= tail_valid;
         if (tail_valid) begin
            res_row_q  <= tail_data[RW+CW-1:CW];
            res_col_q  <= tail_data[CW-1:0];
            res_data_q <= bus.dot_product;
         end
      end
   end

   assign bus.busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign bus.done       = (state_q == ST_DONE);
   assign bus.op_read    = issue;
   assign bus.a_row_addr = row_q;
   assign bus.b_col_addr = col_q;
   assign bus.res_we     = res_we_q;
   assign bus.res_row    = res_row_q;
   assign bus.res_col    = res_col_q;
   assign bus.res_data   = res_data_q;
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - directed self-checking bench for matmul_sequencer (2x3, 2x2 and 1x1 instances)
module tb_matmul_sequencer;
   localparam int RES = 67;

   typedef struct {
      int cyc;
      int row;
      int col;
      logic [RES-1:0] data;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   matmul_sequencer_if #(.RW(1), .CW(2), .RES(RES)) b23 ();
   matmul_sequencer_if #(.RW(1), .CW(1), .RES(RES)) b22 ();
   matmul_sequencer_if #(.RW(1), .CW(1), .RES(RES)) b11 ();

   matmul_sequencer #(.M_ROWS(2), .N_COLS(3)) u23 (.clk_i(clk), .rst_ni(rst_n), .bus(b23.master));
   matmul_sequencer #(.M_ROWS(2), .N_COLS(2)) u22 (.clk_i(clk), .rst_ni(rst_n), .bus(b22.master));
   matmul_sequencer #(.M_ROWS(1), .N_COLS(1)) u11 (.clk_i(clk), .rst_ni(rst_n), .bus(b11.master));

   logic [2:0]     start_v = '0;
   logic [2:0]     hold_v  = '0;
   logic [2:0]     op_v, we_v, done_v, busy_v;
   logic [31:0]    row_v [3];
   logic [31:0]    col_v [3];
   logic [31:0]    rrow_v [3];
   logic [31:0]    rcol_v [3];
   logic [RES-1:0] rdat_v [3];
   logic [RES-1:0] dp [3][4];

   assign b23.start = start_v[0];
   assign b22.start = start_v[1];
   assign b11.start = start_v[2];
   assign b23.hold  = hold_v[0];
   assign b22.hold  = hold_v[1];
   assign b11.hold  = hold_v[2];
   assign b23.dot_product = dp[0][3];
   assign b22.dot_product = dp[1][3];
   assign b11.dot_product = dp[2][3];

   always_comb begin
      op_v     = {b11.op_read, b22.op_read, b23.op_read};
      we_v     = {b11.res_we, b22.res_we, b23.res_we};
      done_v   = {b11.done, b22.done, b23.done};
      busy_v   = {b11.busy, b22.busy, b23.busy};
      row_v[0] = 32'(b23.a_row_addr);
      row_v[1] = 32'(b22.a_row_addr);
      row_v[2] = 32'(b11.a_row_addr);
      col_v[0] = 32'(b23.b_col_addr);
      col_v[1] = 32'(b22.b_col_addr);
      col_v[2] = 32'(b11.b_col_addr);
      rrow_v[0] = 32'(b23.res_row);
      rrow_v[1] = 32'(b22.res_row);
      rrow_v[2] = 32'(b11.res_row);
      rcol_v[0] = 32'(b23.res_col);
      rcol_v[1] = 32'(b22.res_col);
      rcol_v[2] = 32'(b11.res_col);
      rdat_v[0] = b23.res_data;
      rdat_v[1] = b22.res_data;
      rdat_v[2] = b11.res_data;
   end

   // Datapath model: buffer read (1 cycle) then 3 cycles to a row*16+col result.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         for (int k = 3; k > 0; k--) dp[i][k] <= dp[i][k-1];
         dp[i][0] <= op_v[i] ? RES'(row_v[i] * 16 + col_v[i]) : RES'(32'h1BAD);
      end
   end

   int  cyc = 0;
   int  busy_n = 0;
   int  sel = 0;
   ev_t rd_q[$];
   ev_t wr_q[$];
   int  done_q[$];
   int  rb, wb, db, bb;
   int  checks = 0;
   int  failures = 0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (op_v[sel] === 1'b1) rd_q.push_back('{cyc, int'(row_v[sel]), int'(col_v[sel]), {RES{1'b0}}});
      if (we_v[sel] === 1'b1) wr_q.push_back('{cyc, int'(rrow_v[sel]), int'(rcol_v[sel]), rdat_v[sel]});
      if (done_v[sel] === 1'b1) done_q.push_back(cyc);
      if (busy_v[sel] === 1'b1) busy_n = busy_n + 1;
   end

   task automatic start_job(input int s);
      sel = s;
      rb = rd_q.size();
      wb = wr_q.size();
      db = done_q.size();
      bb = busy_n;
      @(posedge clk); #1;
      start_v[s] = 1'b1;
      @(posedge clk); #1;
      start_v[s] = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      int n;
      n = 0;
      while (done_q.size() == db && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      ok = (done_q.size() > db);
      repeat (10) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({op_v[i], we_v[i], done_v[i], busy_v[i]} !== 4'b0) begin
            failures++;
            $display("FAIL reset_strobes inst=%0d got=%b want=0000", i, {op_v[i], we_v[i], done_v[i], busy_v[i]});
         end
         checks++;
         if ({row_v[i], col_v[i], rrow_v[i], rcol_v[i]} !== 128'd0 || rdat_v[i] !== '0) begin
            failures++;
            $display("FAIL reset_fields inst=%0d row=%0d col=%0d rrow=%0d rcol=%0d data=%0h want all 0",
                     i, row_v[i], col_v[i], rrow_v[i], rcol_v[i], rdat_v[i]);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_2x3_job();
      bit ok;
      start_job(0);
      wait_done(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL j23_done_timeout got=none want=done"); end
      checks++;
      if (rd_q.size() - rb !== 6) begin
         failures++; $display("FAIL j23_read_count got=%0d want=6", rd_q.size() - rb);
      end
      for (int i = 0; i < 6 && rb + i < rd_q.size(); i++) begin
         checks++;
         if (rd_q[rb+i].row !== i / 3 || rd_q[rb+i].col !== i % 3 || rd_q[rb+i].cyc !== rd_q[rb].cyc + i) begin
            failures++;
            $display("FAIL j23_read%0d got=(%0d,%0d)@%0d want=(%0d,%0d)@%0d", i, rd_q[rb+i].row,
                     rd_q[rb+i].col, rd_q[rb+i].cyc, i / 3, i % 3, rd_q[rb].cyc + i);
         end
      end
      checks++;
      if (wr_q.size() - wb !== 6) begin
         failures++; $display("FAIL j23_write_count got=%0d want=6", wr_q.size() - wb);
      end
      for (int i = 0; i < 6 && wb + i < wr_q.size(); i++) begin
         checks++;
         if (wr_q[wb+i].row !== i / 3 || wr_q[wb+i].col !== i % 3 ||
             wr_q[wb+i].data !== RES'((i / 3) * 16 + i % 3)) begin
            failures++;
            $display("FAIL j23_write%0d got=(%0d,%0d,%0h) want=(%0d,%0d,%0h)", i, wr_q[wb+i].row,
                     wr_q[wb+i].col, wr_q[wb+i].data, i / 3, i % 3, (i / 3) * 16 + i % 3);
         end
      end
      if (rd_q.size() > rb && wr_q.size() > wb) begin
         checks++;
         if (wr_q[wb].cyc - rd_q[rb].cyc !== 5) begin
            failures++; $display("FAIL j23_first_latency got=%0d want=5", wr_q[wb].cyc - rd_q[rb].cyc);
         end
      end
      checks++;
      if (done_q.size() - db !== 1) begin
         failures++; $display("FAIL j23_done_count got=%0d want=1", done_q.size() - db);
      end
      if (done_q.size() > db && wr_q.size() > wb) begin
         checks++;
         if (done_q[db] - wr_q[wr_q.size()-1].cyc !== 1) begin
            failures++;
            $display("FAIL j23_done_timing got=%0d want=1", done_q[db] - wr_q[wr_q.size()-1].cyc);
         end
      end
      checks++;
      if (row_v[0] !== 0 || col_v[0] !== 0 || busy_v[0] !== 1'b0) begin
         failures++;
         $display("FAIL j23_idle_after got=(%0d,%0d) busy=%b want=(0,0) busy=0", row_v[0], col_v[0], busy_v[0]);
      end
   endtask

   task automatic test_hold();
      bit ok;
      int n;
      start_job(1);
      n = 0;
      while (rd_q.size() - rb < 2 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      hold_v[1] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      hold_v[1] = 1'b0;
      wait_done(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL hold_done_timeout got=none want=done"); end
      checks++;
      if (rd_q.size() - rb !== 4) begin
         failures++; $display("FAIL hold_read_count got=%0d want=4", rd_q.size() - rb);
      end else begin
         checks++;
         if (rd_q[rb+1].cyc - rd_q[rb].cyc !== 1 || rd_q[rb+2].cyc - rd_q[rb+1].cyc !== 4 ||
             rd_q[rb+3].cyc - rd_q[rb+2].cyc !== 1) begin
            failures++;
            $display("FAIL hold_gap got=%0d,%0d,%0d want=1,4,1", rd_q[rb+1].cyc - rd_q[rb].cyc,
                     rd_q[rb+2].cyc - rd_q[rb+1].cyc, rd_q[rb+3].cyc - rd_q[rb+2].cyc);
         end
      end
      checks++;
      if (wr_q.size() - wb !== 4) begin
         failures++; $display("FAIL hold_write_count got=%0d want=4", wr_q.size() - wb);
      end
      for (int i = 0; i < 4 && wb + i < wr_q.size(); i++) begin
         checks++;
         if (wr_q[wb+i].row !== i / 2 || wr_q[wb+i].col !== i % 2 ||
             wr_q[wb+i].data !== RES'((i / 2) * 16 + i % 2)) begin
            failures++;
            $display("FAIL hold_write%0d got=(%0d,%0d,%0h) want=(%0d,%0d,%0h)", i, wr_q[wb+i].row,
                     wr_q[wb+i].col, wr_q[wb+i].data, i / 2, i % 2, (i / 2) * 16 + i % 2);
         end
      end
      checks++;
      if (done_q.size() - db !== 1) begin
         failures++; $display("FAIL hold_done_count got=%0d want=1", done_q.size() - db);
      end
   endtask

   task automatic test_1x1();
      bit ok;
      start_job(2);
      wait_done(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL j11_done_timeout got=none want=done"); end
      checks++;
      if (rd_q.size() - rb !== 1 || wr_q.size() - wb !== 1) begin
         failures++;
         $display("FAIL j11_counts got=rd%0d/wr%0d want=rd1/wr1", rd_q.size() - rb, wr_q.size() - wb);
      end else begin
         checks++;
         if (wr_q[wb].row !== 0 || wr_q[wb].col !== 0 || wr_q[wb].data !== '0 ||
             wr_q[wb].cyc - rd_q[rb].cyc !== 5) begin
            failures++;
            $display("FAIL j11_write got=(%0d,%0d,%0h) lat=%0d want=(0,0,0) lat=5", wr_q[wb].row,
                     wr_q[wb].col, wr_q[wb].data, wr_q[wb].cyc - rd_q[rb].cyc);
         end
      end
      checks++;
      if (busy_n - bb !== 6) begin
         failures++; $display("FAIL j11_busy_cycles got=%0d want=6", busy_n - bb);
      end
      checks++;
      if (done_q.size() - db !== 1) begin
         failures++; $display("FAIL j11_done_count got=%0d want=1", done_q.size() - db);
      end
   endtask

   task automatic test_start_mid_job();
      bit ok;
      start_job(0);
      repeat (2) @(posedge clk);
      #1;
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      wait_done(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL restart_done_timeout got=none want=done"); end
      checks++;
      if (rd_q.size() - rb !== 6 || wr_q.size() - wb !== 6) begin
         failures++;
         $display("FAIL restart_counts got=rd%0d/wr%0d want=rd6/wr6", rd_q.size() - rb, wr_q.size() - wb);
      end
      for (int i = 0; i < 6 && wb + i < wr_q.size(); i++) begin
         checks++;
         if (wr_q[wb+i].row !== i / 3 || wr_q[wb+i].col !== i % 3) begin
            failures++;
            $display("FAIL restart_write%0d got=(%0d,%0d) want=(%0d,%0d)", i, wr_q[wb+i].row,
                     wr_q[wb+i].col, i / 3, i % 3);
         end
      end
      checks++;
      if (done_q.size() - db !== 1) begin
         failures++; $display("FAIL restart_done_count got=%0d want=1", done_q.size() - db);
      end
   endtask

   task automatic test_reset_mid_job();
      bit ok;
      int n;
      int rd_snap;
      int done_snap;
      start_job(0);
      n = 0;
      while (wr_q.size() - wb < 2 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (wr_q.size() - wb !== 2) begin
         failures++; $display("FAIL rstmid_pre_writes got=%0d want=2", wr_q.size() - wb);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({op_v[0], we_v[0], done_v[0], busy_v[0]} !== 4'b0 || row_v[0] !== 0 || col_v[0] !== 0 ||
          rrow_v[0] !== 0 || rcol_v[0] !== 0 || rdat_v[0] !== '0) begin
         failures++;
         $display("FAIL rstmid_outputs got=strb%b row=%0d col=%0d rrow=%0d rcol=%0d data=%0h want all 0",
                  {op_v[0], we_v[0], done_v[0], busy_v[0]}, row_v[0], col_v[0], rrow_v[0], rcol_v[0], rdat_v[0]);
      end
      rd_snap = rd_q.size();
      done_snap = done_q.size();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if (busy_v[0] !== 1'b0 || rd_q.size() !== rd_snap || done_q.size() !== done_snap) begin
         failures++;
         $display("FAIL rstmid_stays_idle got=busy%b reads+%0d dones+%0d want=busy0 reads+0 dones+0",
                  busy_v[0], rd_q.size() - rd_snap, done_q.size() - done_snap);
      end
      start_job(0);
      wait_done(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rstmid_rerun_timeout got=none want=done"); end
      checks++;
      if (rd_q.size() - rb !== 6 || wr_q.size() - wb !== 6 || done_q.size() - db !== 1) begin
         failures++;
         $display("FAIL rstmid_rerun_counts got=rd%0d/wr%0d/done%0d want=rd6/wr6/done1",
                  rd_q.size() - rb, wr_q.size() - wb, done_q.size() - db);
      end
      for (int i = 0; i < 6 && wb + i < wr_q.size(); i++) begin
         checks++;
         if (wr_q[wb+i].row !== i / 3 || wr_q[wb+i].col !== i % 3 ||
             wr_q[wb+i].data !== RES'((i / 3) * 16 + i % 3)) begin
            failures++;
            $display("FAIL rstmid_write%0d got=(%0d,%0d,%0h) want=(%0d,%0d,%0h)", i, wr_q[wb+i].row,
                     wr_q[wb+i].col, wr_q[wb+i].data, i / 3, i % 3, (i / 3) * 16 + i % 3);
         end
      end
   endtask

   initial begin
      test_reset();
      test_2x3_job();
      test_hold();
      test_1x1();
      test_start_mid_job();
      test_reset_mid_job();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
